disp_scan_arb: RTL
==================

Name: disp_scan_arb

Overview:
4-digit 7-segment scan controller that shares the multiplexed display between two requesters.
- Source A: the free-running counter digits; default owner.
- Source B: a message/setting source; takes the display on request.
Generates digit select SA and segment bus L, with PWM brightness and anti-ghost blanking. Source switches occur only at frame boundaries, so a frame is never torn.

Parameters:
SCAN_DIV, 4096, clocks per digit slot; must be a multiple of DIM_STEPS and at least 16
DIM_STEPS, 8, brightness sub-steps per slot (fixed 8, matches BRIGHT width)
HOLD_FRAMES, 1000, full scan frames B keeps the display once granted
GUARD_FRAMES, 250, minimum frames A is shown after B releases before B may be granted again

Ports:
CLK  in  1  system clock
RESET  in  1  asynchronous, active-high reset
A_L1..A_L4  in  8 each  source A segment patterns, digit 0..3, active-low (8'hFF = blank)
B_REQ  in  1  level request from source B
B_L1..B_L4  in  8 each  source B segment patterns, digit 0..3, active-low
BRIGHT  in  3  brightness, 0 = dimmest, 7 = full
B_GNT  out  1  high while B owns the display
SA  out  4  digit select, active-low one-hot (4'hF = all off)
L  out  8  segment bus, active-low
FRAME  out  1  one-clock pulse at each frame boundary

Behaviour:
Reset values:
- SA=4'hF, L=8'hFF, B_GNT=0, FRAME=0.
- Prescaler p=0, digit index d=0, state SHOW_A, hold and guard counters 0.

Scan timing:
- p counts 0..SCAN_DIV-1 and wraps.
- At p=SCAN_DIV-1, d increments mod 4.
- Frame boundary (FB) is the clock where p=SCAN_DIV-1 and d=3.

Digit enable:
- step = p / (SCAN_DIV/DIM_STEPS).
- Digit d is on when p>=1 and step<=BRIGHT.
- p=0 is always blank (anti-ghost).
- BRIGHT=7 gives SCAN_DIV-1 on-clocks per slot.
- BRIGHT=0 gives SCAN_DIV/8-1 on-clocks per slot.
- BRIGHT is sampled live each clock.

Outputs (all registered, 1-clock latency from p/d/state):
- SA[d]=0 when the digit is on; otherwise SA=4'hF.
- L = selected source pattern for digit d when on; otherwise 8'hFF.
- Segment data is live within the frame; only source selection is frame-aligned.
- FRAME = 1 for the clock following FB.

Arbitration FSM (transitions only at FB):
- SHOW_A: source A shown, B_GNT=0. At FB with B_REQ=1 -> SHOW_B, load hold=HOLD_FRAMES-1.
- SHOW_B: source B shown, B_GNT=1.
  - At FB with hold!=0: hold decrements.
  - At FB with hold=0 -> GUARD, load guard=GUARD_FRAMES-1. Applies whether or not B_REQ is still high.
  - B_REQ falling before expiry: at the next FB -> GUARD (early release).
- GUARD: source A shown, B_GNT=0. At FB, guard decrements; at FB with guard=0 -> SHOW_A.
  - B_REQ in GUARD is ignored, not latched.
  - B_REQ still high on entering SHOW_A grants at that state's first FB.
- B_GNT changes on the same edge as the first SA/L of the new source's frame.

Boundary cases:
- B_REQ pulse that is entirely between two FBs is lost (requester holds the level until B_GNT).
- HOLD_FRAMES=1 or GUARD_FRAMES=1 gives exactly one frame in that state.
- RESET mid-frame: outputs go to reset values immediately (async). The first scan after release starts at d=0, p=0.

Decomposition:
- Shared package: DIM_STEPS, state encoding (SHOW_A, SHOW_B, GUARD), SEG_BLANK=8'hFF, SA_OFF=4'hF.
- One sub-module: scan_timebase, holding p/d counters and step, FB and on-enable generation.
- Arbitration FSM and output mux stay in disp_scan_arb.

Test Plan:
(Bench parameters: SCAN_DIV=16, HOLD_FRAMES=3, GUARD_FRAMES=2; A_L1..4=8'hC0,F9,A4,B0; B_L1..4=8'h88,83,C6,A1.)
1. Reset then BRIGHT=7, B_REQ=0:
   - SA cycles 4'hE,D,B,7, each low for 15 of 16 clocks and 4'hF for 1 clock.
   - L=8'hC0 while SA=4'hE.
   - FRAME pulses every 64 clocks.
2. BRIGHT=0: each digit is on for exactly 1 clock (p=1) per 16-clock slot; L=8'hFF whenever SA=4'hF.
3. B_REQ=1 asserted mid-frame and held:
   - Source A is finished for that frame.
   - B_GNT rises at the next FB; L=8'h88 on the first digit-0 on-time.
   - After exactly 3 B frames, B_GNT falls; 2 A frames follow (guard); then B is re-granted.
4. B_REQ=1 for 1 frame, then 0: B is shown for 2 frames (early release at the FB after the drop), then GUARD for 2 frames.
5. B_REQ pulse of 5 clocks between FBs: B_GNT stays 0; L shows A values only.
6. RESET asserted during SHOW_B at p=7: SA=4'hF, L=8'hFF, B_GNT=0 within the same clock; after release the scan restarts at digit 0 in SHOW_A.

Source files
------------

// File: rtl/disp_scan_arb_pkg.sv
// Shared constants and types for the 4-digit scan arbiter.
// Holds the state encoding, blanking constants and the digit-select decoder.
package disp_scan_arb_pkg;

    localparam int DIM_STEPS = 8;

    localparam logic [7:0] SEG_BLANK = 8'hFF;
    localparam logic [3:0] SA_OFF    = 4'hF;

    typedef enum logic [1:0] {
        SHOW_A = 2'd0,
        SHOW_B = 2'd1,
        GUARD  = 2'd2
    } arb_state_t;

    // Active-low one-hot digit select.
    function automatic logic [3:0] digit_sel(input logic [1:0] d);
        return ~(4'b0001 << d);
    endfunction

endpackage

// File: rtl/disp_scan_arb_scan_timebase.sv
// Slot prescaler and digit counter; flags the frame boundary and the PWM on-window.
// All outputs are combinational from the counter registers; there is no backpressure.
module disp_scan_arb_scan_timebase
    import disp_scan_arb_pkg::*;
#(
    parameter int SCAN_DIV = 4096
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] bright,
    output logic [1:0] dig,
    output logic       fb,
    output logic       dig_on
);

    localparam int PW   = $clog2(SCAN_DIV);
    localparam int SLOT = SCAN_DIV / DIM_STEPS;

    logic [PW-1:0] p_q, p_d;
    logic [PW-1:0] step;
    logic [1:0]    d_q, d_d;
    logic          slot_end;

    always_comb begin
        slot_end = (p_q == PW'(SCAN_DIV - 1));
        p_d      = slot_end ? '0 : p_q + 1'b1;
        d_d      = slot_end ? d_q + 2'd1 : d_q;
        step     = p_q / PW'(SLOT);
        fb       = slot_end && (d_q == 2'd3);
        // p=0 stays dark so the previous digit's segments never bleed into this one.
        dig_on   = (p_q != '0) && (step <= PW'(bright));
        dig      = d_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            p_q <= '0;
            d_q <= 2'd0;
        end else begin
            p_q <= p_d;
            d_q <= d_d;
        end
    end

endmodule

// File: rtl/disp_scan_arb.sv
// Multiplexed 7-segment scan controller sharing the display between sources A and B.
// Outputs are registered, one clock behind the scan position; B_REQ has no backpressure and is sampled only at frame boundaries.
module disp_scan_arb
    import disp_scan_arb_pkg::*;
#(
    parameter int SCAN_DIV     = 4096,
    parameter int HOLD_FRAMES  = 1000,
    parameter int GUARD_FRAMES = 250
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic [7:0] A_L1,
    input  logic [7:0] A_L2,
    input  logic [7:0] A_L3,
    input  logic [7:0] A_L4,
    input  logic       B_REQ,
    input  logic [7:0] B_L1,
    input  logic [7:0] B_L2,
    input  logic [7:0] B_L3,
    input  logic [7:0] B_L4,
    input  logic [2:0] BRIGHT,
    output logic       B_GNT,
    output logic [3:0] SA,
    output logic [7:0] L,
    output logic       FRAME
);

    localparam int HW = (HOLD_FRAMES  > 2) ? $clog2(HOLD_FRAMES)  : 1;
    localparam int GW = (GUARD_FRAMES > 2) ? $clog2(GUARD_FRAMES) : 1;

    logic [1:0] dig;
    logic       fb;
    logic       dig_on;

    disp_scan_arb_scan_timebase #(
        .SCAN_DIV (SCAN_DIV)
    ) u_timebase (
        .clk    (CLK),
        .rst    (RESET),
        .bright (BRIGHT),
        .dig    (dig),
        .fb     (fb),
        .dig_on (dig_on)
    );

    arb_state_t    state_q, state_d;
    logic [HW-1:0] hold_q, hold_d;
    logic [GW-1:0] guard_q, guard_d;

    // Ownership only moves at the frame boundary so no frame mixes sources.
    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        guard_d = guard_q;
        if (fb) begin
            case (state_q)
                SHOW_A: begin
                    if (B_REQ) begin
                        state_d = SHOW_B;
                        hold_d  = HW'(HOLD_FRAMES - 1);
                    end
                end
                SHOW_B: begin
                    if (!B_REQ || (hold_q == '0)) begin
                        state_d = GUARD;
                        guard_d = GW'(GUARD_FRAMES - 1);
                    end else begin
                        hold_d = hold_q - 1'b1;
                    end
                end
                GUARD: begin
                    if (guard_q == '0) begin
                        state_d = SHOW_A;
                    end else begin
                        guard_d = guard_q - 1'b1;
                    end
                end
                default: state_d = SHOW_A;
            endcase
        end
    end

    logic [7:0] pat;
    logic [3:0] sa_d, sa_q;
    logic [7:0] l_d, l_q;
    logic       b_gnt_d, b_gnt_q;
    logic       frame_d, frame_q;

    always_comb begin
        pat = SEG_BLANK;
        case (dig)
            2'd0: pat = (state_q == SHOW_B) ? B_L1 : A_L1;
            2'd1: pat = (state_q == SHOW_B) ? B_L2 : A_L2;
            2'd2: pat = (state_q == SHOW_B) ? B_L3 : A_L3;
            2'd3: pat = (state_q == SHOW_B) ? B_L4 : A_L4;
            default: pat = SEG_BLANK;
        endcase
        sa_d    = dig_on ? digit_sel(dig) : SA_OFF;
        l_d     = dig_on ? pat : SEG_BLANK;
        // Registered from the current state so the grant flips with the new frame's first output.
        b_gnt_d = (state_q == SHOW_B);
        frame_d = fb;
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q <= SHOW_A;
            hold_q  <= '0;
            guard_q <= '0;
            sa_q    <= SA_OFF;
            l_q     <= SEG_BLANK;
            b_gnt_q <= 1'b0;
            frame_q <= 1'b0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            guard_q <= guard_d;
            sa_q    <= sa_d;
            l_q     <= l_d;
            b_gnt_q <= b_gnt_d;
            frame_q <= frame_d;
        end
    end

    assign SA    = sa_q;
    assign L     = l_q;
    assign B_GNT = b_gnt_q;
    assign FRAME = frame_q;

endmodule
